// File: rtl/serial_frame_receiver.sv
// Responder for the 19-bit serial address/data link: oversamples InD/InC, decodes
// address and data, drives the ack slots on an address match, reports each frame.
`timescale 1ns/1ps
module serial_frame_receiver #(
    parameter logic [6:0] OWN_ADDR    = 7'h2A,
    parameter logic [6:0] ADDR_MASK   = 7'h7F,
    parameter int         SYNC_STAGES = 2,
    parameter int         TIMEOUT     = 1024
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       InD,
    input  logic       InC,
    output logic [6:0] A_out,
    output logic [7:0] D_out,
    output logic       Valid,
    output logic       AddrMatch,
    output logic       AckD,
    output logic       AckOE,
    output logic       Busy,
    output logic       FrameErr
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_ACK1 = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_ACK2 = 3'd4;
    localparam logic [2:0] ST_STOP = 3'd5;

    logic [SYNC_STAGES-1:0] ind_sync;
    logic [SYNC_STAGES-1:0] inc_sync;
    logic                   inc_prev;
    logic                   ind_s;
    logic                   strobe;

    logic [2:0]    state;
    logic [2:0]    bit_cnt;
    logic [6:0]    shift_addr;
    logic [7:0]    shift_data;
    logic [CW-1:0] tcnt;
    logic          timeout;
    logic          match;

    // Synchronisers preset to 1 so a reset release never looks like an InC edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge reset_n) begin
        if (reset_n) begin
            ind_sync <= '1;
            inc_sync <= '1;
            inc_prev <= 1'b1;
        end else begin
            ind_sync <= {ind_sync[SYNC_STAGES-2:0], InD};
            inc_sync <= {inc_sync[SYNC_STAGES-2:0], InC};
            inc_prev <= inc_sync[SYNC_STAGES-1];
        end
    end

    assign ind_s   = ind_sync[SYNC_STAGES-1];
    assign strobe  = inc_sync[SYNC_STAGES-1] & ~inc_prev;
    assign Busy    = (state != ST_IDLE);
    assign AckD    = 1'b0;
    assign timeout = Busy && (tcnt == CW'(TIMEOUT - 1));
    assign match   = ((({shift_addr[5:0], ind_s}) ^ OWN_ADDR) & ADDR_MASK) == 7'd0;

    // Timeout wins over a strobe in the same cycle; ack-slot samples never steer the FSM.
    always_ff @(posedge clk_in or posedge reset_n) begin
        if (reset_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shift_addr <= 7'd0;
            shift_data <= 8'd0;
            tcnt       <= '0;
            A_out      <= 7'd0;
            D_out      <= 8'd0;
            Valid      <= 1'b0;
            AddrMatch  <= 1'b0;
            AckOE      <= 1'b0;
            FrameErr   <= 1'b0;
        end else begin
            Valid    <= 1'b0;
            FrameErr <= 1'b0;
            if (timeout) begin
                state      <= ST_IDLE;
                FrameErr   <= 1'b1;
                AckOE      <= 1'b0;
                AddrMatch  <= 1'b0;
                tcnt       <= '0;
                bit_cnt    <= 3'd0;
                shift_addr <= 7'd0;
                shift_data <= 8'd0;
            end else if (strobe) begin
                tcnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (!ind_s) begin
                            state   <= ST_ADDR;
                            bit_cnt <= 3'd6;
                        end
                    end
                    ST_ADDR: begin
                        shift_addr <= {shift_addr[5:0], ind_s};
                        if (bit_cnt == 3'd0) begin
                            AddrMatch <= match;
                            AckOE     <= match;
                            state     <= ST_ACK1;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                        end
                    end
                    ST_ACK1: begin
                        AckOE   <= 1'b0;
                        bit_cnt <= 3'd7;
                        state   <= ST_DATA;
                    end
                    ST_DATA: begin
                        shift_data <= {shift_data[6:0], ind_s};
                        if (bit_cnt == 3'd0) begin
                            AckOE <= AddrMatch;
                            state <= ST_ACK2;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                        end
                    end
                    ST_ACK2: begin
                        AckOE <= 1'b0;
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (ind_s) begin
                            FrameErr <= 1'b1;
                        end else if (AddrMatch) begin
                            A_out <= shift_addr;
                            D_out <= shift_data;
                            Valid <= 1'b1;
                        end
                        AddrMatch <= 1'b0;
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (Busy) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Responder end of the 19-bit serial address/data link, whose frame is start, 7-bit address, ack slot, 8-bit data, ack slot, end bit.
- Oversamples the serial data line (InD) and serial strobe (InC) on the local clock and decodes the address and data fields.
- Drives low on both ack slots when the address matches.
- Presents each completed frame as a one-cycle Valid strobe with parallel A_out/D_out.

Parameters:
- OWN_ADDR, 7'h2A, responder address compared against the received address.
- ADDR_MASK, 7'h7F, a 1 bit means that address bit participates in the compare.
- SYNC_STAGES, 2, synchroniser depth on InD and InC; legal range 2..4.
- TIMEOUT, 1024, clk_in cycles without an InC rising edge before a frame in progress is abandoned.

Ports:
- clk_in  in  1  local clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous reset, active-high; despite the name, 1 = reset.
- InD  in  1  serial data line; idle high; MSB first.
- InC  in  1  serial bit strobe; InD is valid at each InC rising edge.
- A_out  out  7  address of the last accepted frame.
- D_out  out  8  data of the last accepted frame.
- Valid  out  1  one-cycle pulse when a matched frame completes correctly.
- AddrMatch  out  1  high from the address decision until the frame ends.
- AckD  out  1  ack value; constant 0.
- AckOE  out  1  ack output enable; the line is pulled low only while this is 1.
- Busy  out  1  high whenever the FSM is not IDLE.
- FrameErr  out  1  one-cycle pulse on a bad end bit or on timeout.

Behaviour:
- Reset (asynchronous assert, synchronous release to clk_in):
  - A_out=0, D_out=0, Valid=0, AddrMatch=0, AckD=0, AckOE=0, Busy=0, FrameErr=0.
  - FSM goes to IDLE, counters clear, synchronisers load 1.
- Sampling:
  - InD and InC pass through SYNC_STAGES flops.
  - An InC rising edge is detected from the last two synced InC values; call this cycle S.
  - Every field bit is captured from synced InD in cycle S.
  - Pin-to-S latency is SYNC_STAGES+1 clk_in cycles.
- FSM states:
  - IDLE: at S with InD=0 go to ADDR (start bit). At S with InD=1 stay in IDLE, no error.
  - ADDR: shift 7 bits MSB first, bit counter 6..0. At the 7th S, compute match = ((addr ^ OWN_ADDR) & ADDR_MASK) == 0. Latch AddrMatch. Set AckOE=match in the following cycle. Go to ACK1.
  - ACK1: the next S is the ack slot; the sampled value is ignored. AckOE drops in the cycle after that S. Go to DATA.
  - DATA: shift 8 bits MSB first. At the 8th S, set AckOE=AddrMatch in the following cycle. Go to ACK2.
  - ACK2: the next S is the ack slot; AckOE drops in the cycle after it. Go to STOP.
  - STOP:
    - At S with InD=0 and AddrMatch=1: load A_out/D_out, pulse Valid for the cycle after S.
    - At S with InD=0 and AddrMatch=0: silent, no outputs change.
    - At S with InD=1: pulse FrameErr; A_out/D_out are not updated.
    - All three cases go to IDLE and clear AddrMatch.
- Timeout:
  - The cycle counter resets at every S and counts while Busy=1.
  - When it reaches TIMEOUT: pulse FrameErr, force AckOE=0, clear AddrMatch, go to IDLE, discard partial fields.
- Simultaneous events: reset overrides everything. A timeout and an S in the same cycle resolve to the timeout.
- A_out/D_out hold their values between accepted frames. Valid and FrameErr never assert in the same cycle.
- InC edges arriving back-to-back must be at least 2 clk_in cycles apart for correct operation. Behaviour for faster strobes is undefined.
- The ack slot carries 1'bZ from the initiator. A synced X or Z value is never used for a decision.

Test Plan:
- Matched frame:
  - Stimulus: A=7'h2A, D=8'hC3, end bit 0, InC period 8 clk_in cycles.
  - Required: AckOE high across both ack slots; Valid pulses once; A_out=7'h2A, D_out=8'hC3; FrameErr=0.
- Mismatched frame:
  - Stimulus: A=7'h15, D=8'hFF.
  - Required: AckOE never 1; Valid=0; A_out/D_out keep their previous values (7'h2A/8'hC3); Busy returns to 0 after the end bit.
- Mask:
  - Stimulus: ADDR_MASK=7'h70, A=7'h2F, D=8'h01.
  - Required: match; Valid pulses; A_out=7'h2F, D_out=8'h01.
- Bad end bit:
  - Stimulus: matched frame with end bit 1.
  - Required: FrameErr pulses 1 cycle; Valid=0; outputs unchanged; the next correct frame with D=8'h5A is accepted.
- Timeout and reset mid-frame:
  - Stimulus: stop InC after 4 address bits.
  - Required: FrameErr pulses exactly TIMEOUT cycles after the last S; FSM returns to IDLE.
  - Stimulus: assert reset_n during DATA with AckOE=1.
  - Required: AckOE=0 and Busy=0 asynchronously.
- Idle robustness:
  - Stimulus: 50 InC edges with InD=1.
  - Required: no Busy, Valid or FrameErr activity.
